// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// segment bit order, hex glyph table and pin polarity helpers.
package seg_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Active-high {a,b,c,d,e,f,g} patterns for 0..9, A, b, C, d, E, F
    localparam logic [6:0] GLYPHS [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic logic [6:0] pol_seg(input logic [6:0] value, input logic act_low);
        pol_seg = value ^ {7{act_low}};
    endfunction

    function automatic logic pol_bit(input logic value, input logic act_low);
        pol_bit = value ^ act_low;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high 7-segment glyph lookup.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Glyph table lookup
    always_comb begin
        glyph = GLYPHS[nibble];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with double-buffered
// digit data, per-digit blink/dp, PWM brightness and leading-zero blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG         = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BRT_W        = 3,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACT_LOW      = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*NDIG-1:0]   din,
    input  logic [NDIG-1:0]     dp_in,
    input  logic [NDIG-1:0]     blink_en,
    input  logic                lz_en,
    input  logic [BRT_W-1:0]    brightness,
    input  logic                load,
    output logic                load_ack,
    output logic                frame_start,
    output logic [6:0]          seg,
    output logic [NDIG-1:0]     an,
    output logic                dp
);

    localparam int SW   = $clog2(SCAN_DIV);
    localparam int IW   = $clog2(NDIG);
    localparam int BW   = $clog2(BLINK_FRAMES + 1);
    localparam int UNIT = SCAN_DIV >> BRT_W;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SLOT_PRE   = SW'(SCAN_DIV - 2);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [SW-1:0]      slot_cnt_r;
    logic [IW-1:0]      idx_r;
    logic [BW-1:0]      blink_cnt_r;
    logic               blink_phase_r;
    logic               frame_start_r;
    logic [4*NDIG-1:0]  sh_data_r;
    logic [NDIG-1:0]    sh_dp_r;
    logic [NDIG-1:0]    sh_blink_r;
    logic [6:0]         seg_r;
    logic [NDIG-1:0]    an_r;
    logic               dp_r;

    logic               slot_end_s;
    logic               capture_s;
    logic [SW:0]        on_raw_s;
    logic [SW-1:0]      on_time_s;
    logic               lit_s;
    logic               zero_run_s;
    logic [NDIG-1:0]    blank_s;
    logic [4*NDIG-1:0]  nib_shift_s;
    logic [3:0]         nib_s;
    logic               blank_sel_s;
    logic [6:0]         glyph_s;
    logic [NDIG-1:0]    an_act_s;

    assign slot_end_s  = (slot_cnt_r == SLOT_LAST);
    assign capture_s   = frame_start_r & load;
    assign load_ack    = capture_s;
    assign frame_start = frame_start_r;
    assign seg         = seg_r;
    assign an          = an_r;
    assign dp          = dp_r;

    // Slot and digit scan counters; frame_start is decoded one cycle early so it is a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_r    <= '0;
            idx_r         <= '0;
            frame_start_r <= 1'b0;
        end else begin
            if (slot_end_s) begin
                slot_cnt_r <= '0;
                idx_r      <= (idx_r == IDX_LAST) ? '0 : idx_r + 1'b1;
            end else begin
                slot_cnt_r <= slot_cnt_r + 1'b1;
            end
            frame_start_r <= (slot_cnt_r == SLOT_PRE) && (idx_r == IDX_LAST);
        end
    end

    // Frame-rate blink divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if (frame_start_r) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + 1'b1;
            end
        end else begin
            blink_cnt_r <= blink_cnt_r;
        end
    end

    // Shadow registers only change on a frame boundary so a frame is never torn
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_data_r  <= '0;
            sh_dp_r    <= '0;
            sh_blink_r <= '0;
        end else if (capture_s) begin
            sh_data_r  <= din;
            sh_dp_r    <= dp_in;
            sh_blink_r <= blink_en;
        end else begin
            sh_data_r  <= sh_data_r;
        end
    end

    // On-time window, leading-zero mask and the anode/segment selection for the current slot
    always_comb begin
        on_raw_s = (SW+1)'((int'(brightness) + 1) * UNIT);
        if (on_raw_s > {1'b0, SLOT_LAST}) begin
            on_time_s = SLOT_LAST;
        end else begin
            on_time_s = on_raw_s[SW-1:0];
        end
        lit_s = (slot_cnt_r != '0) && (slot_cnt_r <= on_time_s);

        blank_s    = '0;
        zero_run_s = lz_en;
        for (int i = NDIG - 1; i >= 1; i--) begin
            zero_run_s = zero_run_s && (sh_data_r[4*i +: 4] == 4'h0);
            blank_s[i] = zero_run_s;
        end

        nib_shift_s = sh_data_r >> {idx_r, 2'b00};
        nib_s       = nib_shift_s[3:0];
        blank_sel_s = blank_s[idx_r];

        an_act_s        = '0;
        an_act_s[idx_r] = lit_s & ~blank_sel_s & ~(blink_phase_r & sh_blink_r[idx_r]);
    end

    seg_hex_decode u_dec (
        .nibble (nib_s),
        .glyph  (glyph_s)
    );

    // Registered pin drivers with polarity applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= pol_seg(7'h00, ACT_LOW);
            an_r  <= {NDIG{ACT_LOW}};
            dp_r  <= pol_bit(1'b0, ACT_LOW);
        end else begin
            seg_r <= pol_seg(glyph_s, ACT_LOW);
            an_r  <= an_act_s ^ {NDIG{ACT_LOW}};
            dp_r  <= pol_bit(sh_dp_r[idx_r] & ~blank_sel_s, ACT_LOW);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised scoreboard bench for seg_scan_ctrl: an active-low and an
// active-high instance are compared every cycle against a frame-level model.
module tb_seg_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int SD    = 8;
    localparam int BRT_W = 3;
    localparam int BF    = 2;
    localparam int FRAME = SD * NDIG;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blink_en = 4'h0;
    logic        lz_en = 1'b0;
    logic [2:0]  brightness = 3'd0;
    logic        load = 1'b0;

    logic        ack0, fs0, dp0, ack1, fs1, dp1;
    logic [6:0]  seg0, seg1;
    logic [3:0]  an0, an1;

    seg_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SD), .BRT_W(BRT_W), .BLINK_FRAMES(BF), .ACT_LOW(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .din(din), .dp_in(dp_in), .blink_en(blink_en), .lz_en(lz_en),
        .brightness(brightness), .load(load), .load_ack(ack0), .frame_start(fs0),
        .seg(seg0), .an(an0), .dp(dp0));

    seg_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SD), .BRT_W(BRT_W), .BLINK_FRAMES(BF), .ACT_LOW(1'b0)) dut_hi (
        .clk(clk), .rst_n(rst_n), .din(din), .dp_in(dp_in), .blink_en(blink_en), .lz_en(lz_en),
        .brightness(brightness), .load(load), .load_ack(ack1), .frame_start(fs1),
        .seg(seg1), .an(an1), .dp(dp1));

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
        logic       dp;
        logic       fs;
        logic       ack;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;

    // Model state: cycles since reset release and the captured display contents
    int          cyc = 0;
    logic [15:0] m_data = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    logic [3:0]  m_blink = 4'h0;

    // Next-cycle stimulus values, applied by tick()
    logic [15:0] nx_d = 16'h0;
    logic [3:0]  nx_dp = 4'h0;
    logic [3:0]  nx_bl = 4'h0;
    logic        nx_lz = 1'b0;
    logic [2:0]  nx_br = 3'd0;
    logic        nx_ld = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t, cycle %0d)", name, act, req, $time, cyc);
        end
    endtask

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0:  return 7'b1111110;
            1:  return 7'b0110000;
            2:  return 7'b1101101;
            3:  return 7'b1111001;
            4:  return 7'b0110011;
            5:  return 7'b1011011;
            6:  return 7'b1011111;
            7:  return 7'b1110000;
            8:  return 7'b1111111;
            9:  return 7'b1111011;
            10: return 7'b1110111;
            11: return 7'b0011111;
            12: return 7'b1001110;
            13: return 7'b0111101;
            14: return 7'b1001111;
            15: return 7'b1000111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Active-high pin values selected by the state of cycle cc (they appear one cycle later)
    function automatic exp_t model_out(input int cc);
        exp_t e;
        int slot, dig, frame, on_t;
        bit blank, lit, phase;
        slot  = cc % SD;
        dig   = (cc / SD) % NDIG;
        frame = cc / FRAME;
        on_t  = (int'(brightness) + 1) * (SD >> BRT_W);
        if (on_t > SD - 1) on_t = SD - 1;
        blank = 1'b0;
        if (lz_en && dig != 0) begin
            blank = 1'b1;
            for (int k = dig; k < NDIG; k++)
                if (m_data[4*k +: 4] != 4'h0) blank = 1'b0;
        end
        phase = ((frame / BF) % 2) == 1;
        lit = (slot != 0) && (slot <= on_t) && !blank && !(phase && m_blink[dig]);
        e.seg = glyph(int'(m_data[4*dig +: 4]));
        e.an  = lit ? 4'(1 << dig) : 4'h0;
        e.dp  = m_dp[dig] && !blank;
        e.fs  = 1'b0;
        e.ack = 1'b0;
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        e = model_out(cyc);
        if ((cyc % FRAME) == FRAME - 1 && load) begin
            m_data  = din;
            m_dp    = dp_in;
            m_blink = blink_en;
        end
        cyc++;
        #1;
        din = nx_d; dp_in = nx_dp; blink_en = nx_bl;
        lz_en = nx_lz; brightness = nx_br; load = nx_ld;
        e.fs  = (cyc % FRAME) == FRAME - 1;
        e.ack = e.fs && nx_ld;
        sb.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_seg_lo", 32'(seg0), 32'h7F);
        check("rst_an_lo", 32'(an0), 32'hF);
        check("rst_dp_lo", 32'(dp0), 32'h1);
        check("rst_fs", 32'(fs0), 32'h0);
        check("rst_ack", 32'(ack0), 32'h0);
        check("rst_seg_hi", 32'(seg1), 32'h00);
        check("rst_an_hi", 32'(an1), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        m_data = 16'h0; m_dp = 4'h0; m_blink = 4'h0;
    endtask

    // Scoreboard monitor: compare both instances with the queued expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        logic [6:0] es;
        logic [3:0] ea;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            es = ~e.seg;
            ea = ~e.an;
            check("seg_lo", 32'(seg0), 32'(es));
            check("an_lo", 32'(an0), 32'(ea));
            check("dp_lo", 32'(dp0), 32'(!e.dp));
            check("fs_lo", 32'(fs0), 32'(e.fs));
            check("ack_lo", 32'(ack0), 32'(e.ack));
            check("seg_hi", 32'(seg1), 32'(e.seg));
            check("an_hi", 32'(an1), 32'(e.an));
            check("dp_hi", 32'(dp1), 32'(e.dp));
            check("fs_hi", 32'(fs1), 32'(e.fs));
        end
    end

    initial begin
        do_reset();
        run(40);

        // Load held across two frame boundaries, then dropped
        nx_d = 16'h1234; nx_ld = 1'b1; nx_br = 3'd7;
        run(64);
        nx_ld = 1'b0; nx_d = 16'hFFFF;
        run(64);

        // Brightness extremes, then random per-cycle brightness
        nx_br = 3'd0;
        run(32);
        nx_br = 3'd7;
        run(32);
        for (int i = 0; i < 64; i++) begin
            nx_br = 3'($urandom_range(0, 7));
            tick();
        end

        // Leading-zero blanking with partial, all-zero and dp-on-blank data
        nx_lz = 1'b1; nx_br = 3'd7; nx_d = 16'h0050; nx_ld = 1'b1;
        run(32);
        nx_ld = 1'b0;
        run(64);
        nx_d = 16'h0000; nx_dp = 4'b1000; nx_ld = 1'b1;
        run(32);
        nx_ld = 1'b0;
        run(64);

        // Mid-frame reset, then blink on digit 1 over six frames
        run(13);
        do_reset();
        nx_lz = 1'b0; nx_dp = 4'b0101; nx_bl = 4'b0010; nx_d = 16'h8888; nx_ld = 1'b1;
        run(33);
        nx_ld = 1'b0;
        run(6 * FRAME);

        // Randomised traffic on all inputs
        for (int i = 0; i < 40 * FRAME; i++) begin
            if ($urandom_range(0, 15) == 0) nx_d  = 16'($urandom);
            if ($urandom_range(0, 15) == 0) nx_dp = 4'($urandom);
            if ($urandom_range(0, 15) == 0) nx_bl = 4'($urandom);
            if ($urandom_range(0, 31) == 0) nx_lz = 1'($urandom);
            if ($urandom_range(0, 15) == 0) nx_br = 3'($urandom);
            if ($urandom_range(0, 7) == 0)  nx_ld = 1'($urandom);
            if ($urandom_range(0, 7) == 0 && nx_d[15:12] != 4'h0) nx_d[15:8] = 8'h00;
            tick();
        end

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
